// File: rtl/wb_result_stage.sv
// Write-back result stage: selects one of NUM_SRC sources and holds it in a one-entry valid/ready slot.
// Optional WB_LOAD_BYPASS_EN: a load accepted while mem_rvalid_i is high completes directly to FULL.
module wb_result_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_SRC  = 5,
  parameter int SEL_W    = 3,
  parameter int LOAD_SEL = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic [NUM_SRC*DATA_W-1:0] srcs_i,
  input  logic [4:0]                rd_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATA_W-1:0]         result_o,
  output logic [4:0]                rd_o,
  output logic                      sel_err_o
);

  // state    | meaning
  // S_IDLE   | slot empty, accepts a new result
  // S_WAIT   | load accepted, waiting for mem_rvalid_i
  // S_FULL   | result held, valid_o high until ready_i
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FULL} state_t;

  localparam logic [SEL_W:0] NUM_SRC_W = (SEL_W+1)'(NUM_SRC);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [4:0]         rd_q, rd_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  src_sel;
  logic               accept, sel_in_range, sel_is_load;

  always_comb begin
    src_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_i == SEL_W'(k)) src_sel = srcs_i[k*DATA_W +: DATA_W];
    end
  end

  assign sel_in_range = ({1'b0, sel_i} < NUM_SRC_W);
  assign sel_is_load  = (sel_i == SEL_W'(LOAD_SEL));
  assign ready_o      = (state_q == S_IDLE) | ((state_q == S_FULL) & ready_i);
  assign accept       = valid_i & ready_o;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rd_d     = rd_q;
    err_d    = err_q;
    case (state_q)
      S_WAIT: begin
        if (mem_rvalid_i) begin
          result_d = mem_rdata_i;
          err_d    = 1'b0;
          state_d  = S_FULL;
        end
      end
      S_IDLE, S_FULL: begin
        if (accept) begin
          rd_d = rd_i;
          if (!sel_in_range) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = S_FULL;
          end else if (sel_is_load) begin
`ifdef WB_LOAD_BYPASS_EN
            if (mem_rvalid_i) begin
              result_d = mem_rdata_i;
              err_d    = 1'b0;
              state_d  = S_FULL;
            end else begin
              state_d  = S_WAIT;
            end
`else
            state_d = S_WAIT;
`endif
          end else begin
            result_d = src_sel;
            err_d    = 1'b0;
            state_d  = S_FULL;
          end
        end else if (state_q == S_FULL && ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

  assign valid_o   = (state_q == S_FULL);
  assign result_o  = result_q;
  assign rd_o      = rd_q;
  assign sel_err_o = err_q;

endmodule

// File: tb/tb_wb_result_stage.sv
// Self-checking bench for wb_result_stage: directed vector table, hand sequences, random vs reference model.
module tb_wb_result_stage;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [2:0]   sel_i = '0;
  logic [159:0] srcs_i = '0;
  logic [4:0]   rd_i = '0;
  logic         mem_rvalid_i = 1'b0;
  logic [31:0]  mem_rdata_i = '0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [31:0]  result_o;
  logic [4:0]   rd_o;
  logic         sel_err_o;

  int n_cmp = 0;
  int n_err = 0;

  wb_result_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .sel_i(sel_i), .srcs_i(srcs_i), .rd_i(rd_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .rd_o(rd_o), .sel_err_o(sel_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] r,
                         input logic [4:0] d, input logic e);
    chk({tag, ".valid_o"}, 32'(valid_o), 32'(v));
    chk({tag, ".result_o"}, result_o, r);
    chk({tag, ".rd_o"}, 32'(rd_o), 32'(d));
    chk({tag, ".sel_err_o"}, 32'(sel_err_o), 32'(e));
  endtask

  function automatic logic [159:0] pack_base(input logic [31:0] base);
    logic [159:0] f;
    for (int k = 0; k < 5; k++) f[k*32 +: 32] = base + 32'(k);
    return f;
  endfunction

  task automatic drive(input logic v, input logic [2:0] s, input logic [159:0] src,
                       input logic [4:0] d, input logic rdy, input logic rv, input logic [31:0] rdat);
    valid_i = v; sel_i = s; srcs_i = src; rd_i = d;
    ready_i = rdy; mem_rvalid_i = rv; mem_rdata_i = rdat;
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic [31:0] base;
    logic [4:0]  rd;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        x_ready;
    logic        x_valid;
    logic [31:0] x_result;
    logic [4:0]  x_rd;
    logic        x_err;
  } vec_t;

  vec_t tbl[14];

  // Behavioural reference: slot contents plus whether a load is outstanding.
  logic        m_full, m_wait, m_err;
  logic [31:0] m_result;
  logic [4:0]  m_rd;
  logic [31:0] src_arr[5];

  function automatic logic m_ready();
    return (!m_full && !m_wait) || (m_full && ready_i);
  endfunction

  task automatic model_reset();
    m_full = 0; m_wait = 0; m_err = 0; m_result = 0; m_rd = 0;
  endtask

  task automatic model_edge();
    logic acc;
    acc = valid_i && m_ready();
    if (m_wait) begin
      if (mem_rvalid_i) begin
        m_result = mem_rdata_i; m_err = 0; m_wait = 0; m_full = 1;
      end
    end else if (acc) begin
      m_rd = rd_i;
      if (int'(sel_i) >= 5) begin
        m_result = 0; m_err = 1; m_full = 1;
      end else if (int'(sel_i) == 1) begin
`ifdef WB_LOAD_BYPASS_EN
        if (mem_rvalid_i) begin
          m_result = mem_rdata_i; m_err = 0; m_full = 1;
        end else begin
          m_wait = 1; m_full = 0;
        end
`else
        m_wait = 1; m_full = 0;
`endif
      end else begin
        m_result = src_arr[sel_i]; m_err = 0; m_full = 1;
      end
    end else if (m_full && ready_i) begin
      m_full = 0;
    end
  endtask

  initial begin
    // v sel base rd rdy rv rdata | ready valid result rd err
    tbl[0]  = '{1, 3'd0, 32'hDEAD_BEEF, 5'd5, 1, 0, 32'h0, 1, 1, 32'hDEAD_BEEF, 5'd5, 0};
    tbl[1]  = '{1, 3'd2, 32'h1000_0000, 5'd6, 1, 0, 32'h0, 1, 1, 32'h1000_0002, 5'd6, 0};
    tbl[2]  = '{1, 3'd3, 32'h2000_0000, 5'd7, 1, 0, 32'h0, 1, 1, 32'h2000_0003, 5'd7, 0};
    tbl[3]  = '{1, 3'd4, 32'h3000_0000, 5'd8, 1, 0, 32'h0, 1, 1, 32'h3000_0004, 5'd8, 0};
    tbl[4]  = '{1, 3'd6, 32'h4000_0000, 5'd9, 1, 0, 32'h0, 1, 1, 32'h0, 5'd9, 1};
    tbl[5]  = '{1, 3'd0, 32'h5000_0000, 5'd10, 0, 0, 32'h0, 0, 1, 32'h0, 5'd9, 1};
    tbl[6]  = '{1, 3'd0, 32'h5000_0000, 5'd10, 1, 0, 32'h0, 1, 1, 32'h5000_0000, 5'd10, 0};
    tbl[7]  = '{0, 3'd0, 32'h6000_0000, 5'd0, 1, 0, 32'h0, 1, 0, 32'h5000_0000, 5'd10, 0};
    tbl[8]  = '{1, 3'd1, 32'h7000_0000, 5'd7, 1, 0, 32'h0, 1, 0, 32'h5000_0000, 5'd7, 0};
    tbl[9]  = '{0, 3'd0, 32'h7000_0000, 5'd0, 1, 0, 32'h0, 0, 0, 32'h5000_0000, 5'd7, 0};
    tbl[10] = '{1, 3'd0, 32'h8000_0000, 5'd3, 1, 1, 32'h1234_5678, 0, 1, 32'h1234_5678, 5'd7, 0};
    tbl[11] = '{0, 3'd0, 32'h8000_0000, 5'd0, 1, 0, 32'h0, 1, 0, 32'h1234_5678, 5'd7, 0};
`ifdef WB_LOAD_BYPASS_EN
    tbl[12] = '{1, 3'd1, 32'h9000_0000, 5'd11, 1, 1, 32'hA5A5_A5A5, 1, 1, 32'hA5A5_A5A5, 5'd11, 0};
    tbl[13] = '{0, 3'd0, 32'h9000_0000, 5'd0, 1, 1, 32'h0BAD_F00D, 1, 0, 32'hA5A5_A5A5, 5'd11, 0};
`else
    tbl[12] = '{1, 3'd1, 32'h9000_0000, 5'd11, 1, 1, 32'hA5A5_A5A5, 1, 0, 32'h1234_5678, 5'd11, 0};
    tbl[13] = '{0, 3'd0, 32'h9000_0000, 5'd0, 1, 1, 32'h0BAD_F00D, 0, 1, 32'h0BAD_F00D, 5'd11, 0};
`endif

    // Power-on reset
    #2;
    chk_out("por", 0, 32'h0, 5'd0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1 chk("por.ready_o", 32'(ready_o), 32'd1);
    @(negedge clk_i);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].sel, pack_base(tbl[i].base), tbl[i].rd,
            tbl[i].rdy, tbl[i].rv, tbl[i].rdata);
      #1 chk($sformatf("vec%0d.ready_o", i), 32'(ready_o), 32'(tbl[i].x_ready));
      @(posedge clk_i);
      @(negedge clk_i);
      chk_out($sformatf("vec%0d", i), tbl[i].x_valid, tbl[i].x_result, tbl[i].x_rd, tbl[i].x_err);
    end

    // Reset while a load is pending; later rvalid must be ignored
    drive(1, 3'd1, pack_base(32'hC000_0000), 5'd20, 1, 0, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    drive(0, 3'd0, '0, 5'd0, 1, 0, 32'h0);
    #1 chk("wait.ready_o", 32'(ready_o), 32'd0);
    rst_ni = 1'b0;
    #1 chk_out("rst_mid", 0, 32'h0, 5'd0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 3'd0, '0, 5'd0, 1, 1, 32'hFFFF_0000);
    #1 chk("rst_rel.ready_o", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    chk_out("rst_rvalid_ignored", 0, 32'h0, 5'd0, 0);

    // Backpressure: held result stays stable while srcs_i toggles, then no bubble
    drive(1, 3'd2, pack_base(32'h6000_0000), 5'd12, 0, 0, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    chk_out("bp_load", 1, 32'h6000_0002, 5'd12, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'(i % 2 == 0 ? 2 : 3), pack_base(32'hA000_0000 + 32'(i) * 32'h100), 5'(i), 0, 0, 32'h0);
      #1 chk($sformatf("bp%0d.ready_o", i), 32'(ready_o), 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      chk_out($sformatf("bp%0d", i), 1, 32'h6000_0002, 5'd12, 0);
    end
    drive(1, 3'd4, pack_base(32'h7000_0000), 5'd13, 1, 0, 32'h0);
    #1 chk("bp_rel.ready_o", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    chk_out("bp_next", 1, 32'h7000_0004, 5'd13, 0);

    // Randomized run against the reference model
    rst_ni = 1'b0;
    drive(0, 3'd0, '0, 5'd0, 0, 0, 32'h0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 400; c++) begin
      logic [159:0] f;
      for (int k = 0; k < 5; k++) begin
        src_arr[k] = $urandom;
        f[k*32 +: 32] = src_arr[k];
      end
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), f, 5'($urandom),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 2) == 0), $urandom);
      #1 chk($sformatf("rnd%0d.ready_o", c), 32'(ready_o), 32'(m_ready()));
      @(posedge clk_i);
      model_edge();
      @(negedge clk_i);
      chk_out($sformatf("rnd%0d", c), m_full, m_result, m_rd, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
